match_state_ctrl: RTL
=====================

Name: match_state_ctrl

Overview:
- Parametrised successor to the two-player round/win state machine: N-player Tron match controller with per-player scoring, best-of-K match, and wrap-around map selection.
- Sits between the keyboard keycode path and the background loader, player movers and HUD. Consumes per-player crash strobes; produces game state, map select, alive mask and scores.

Parameters:
- NUM_PLAYERS, 2, players in match (2..4); PID_W = max(1,$clog2(NUM_PLAYERS)).
- NUM_MAPS, 2, playable maps (1..7); background 0 is the menu screen; BG_W = $clog2(NUM_MAPS+1).
- ROUNDS_TO_WIN, 3, round wins needed to take the match; SCORE_W = $clog2(ROUNDS_TO_WIN+1).
- HOLD_CYCLES, 16, minimum cycles spent in ROUND_OVER/MATCH_OVER before a key is accepted (>=1).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous, active-low reset.
- Reset_Game  in  1  sync, active-high; abort to MENU.
- Reset_Round  in  1  sync, active-high; restart the current round (ROUND_RUN only).
- keycode  in  8  current USB keycode, 0 = none.
- Crash  in  NUM_PLAYERS  one bit per player, high = player crashed this cycle.
- Game_State  out  3  MENU=0, ROUND_READY=1, ROUND_RUN=2, ROUND_OVER=3, MATCH_OVER=4.
- background_select  out  BG_W  0 in MENU/MATCH_OVER, else map_sel+1.
- load_background  out  1  one-cycle pulse on every entry to ROUND_READY.
- alive  out  NUM_PLAYERS  live-player mask.
- scores  out  NUM_PLAYERS*SCORE_W  packed scores, player 0 in the LSBs.
- winner_id  out  PID_W  last round winner; match winner while in MATCH_OVER.
- winner_valid  out  1  high in ROUND_OVER/MATCH_OVER when winner_id is meaningful (0 on draw).

Behaviour:
- Reset (Reset_n=0 at posedge): state MENU, map_sel 0, scores 0, alive all-1, winner_id 0, winner_valid 0, load_background 0, old keycode 0, hold counter 0.
- Key press: press = (keycode!=0) && (keycode!=old_keycode). old_keycode registers every cycle. Holding a key yields exactly one press.
- Priority per cycle: Reset_n > Reset_Game > Reset_Round > Crash > press.
- Reset_Game: next state MENU, scores cleared, alive all-1, map_sel kept.
- MENU:
  - Up press (0x1A or 0x52): map_sel+1, wrapping NUM_MAPS-1 -> 0.
  - Down press (0x16 or 0x51): map_sel-1, wrapping 0 -> NUM_MAPS-1.
  - Enter press (0x28): go to ROUND_READY.
  - NUM_MAPS=1: map_sel stays 0.
- ROUND_READY: alive all-1. Any press goes to ROUND_RUN. Crash is ignored.
- ROUND_RUN:
  - Compute alive_n = alive & ~Crash, registered next edge.
  - If popcount(alive_n) <= 1: go to ROUND_OVER on the same edge.
    - Exactly one survivor: that player's score +1; winner_id = its index; winner_valid 1.
    - Zero survivors (simultaneous crash): draw, no score change, winner_valid 0.
  - Key presses are ignored.
  - Reset_Round: go to ROUND_READY, no score change, crash that cycle discarded.
- ROUND_OVER:
  - Hold counter loads HOLD_CYCLES-1 on entry and decrements to 0.
  - Presses are ignored until the counter reaches 0.
  - After that, a press goes to MATCH_OVER if any score == ROUNDS_TO_WIN, else to ROUND_READY.
- MATCH_OVER:
  - winner_id = lowest index with score == ROUNDS_TO_WIN; winner_valid 1.
  - Same hold rule as ROUND_OVER; then a press goes to MENU.
  - Scores clear on the edge entering MENU.
- Scores never exceed ROUNDS_TO_WIN: increment saturates.
- Illegal state encoding: go to MENU next cycle.
- load_background is registered: high the cycle after the transition edge into ROUND_READY, for exactly one cycle.

Decomposition:
- Package tron_game_pkg: game_state_t enum (3-bit encodings above), key constants KEY_ENTER=8'h28, KEY_W=8'h1A, KEY_UP=8'h52, KEY_S=8'h16, KEY_DOWN=8'h51.
- Sub-module key_edge_detect: registers keycode and outputs press plus the registered keycode.
- Survivor popcount and index encode are functions in the package.

Test Plan:
- Map wrap: NUM_MAPS=3, MENU, press Down from map 0 -> map_sel 2, background_select 0. Then Up x1 -> 0. Enter -> Game_State 1, background_select 1, load_background high 1 cycle.
- Key hold: keycode 0x52 held 10 cycles in MENU -> map_sel advances by exactly 1.
- Single survivor: 2 players, ROUND_RUN, Crash=2'b10 -> next cycle Game_State 3, scores[0]=1, winner_id 0, winner_valid 1. A press before 16 cycles -> no change.
- Draw: Crash=2'b11 same cycle -> Game_State 3, scores unchanged, winner_valid 0.
- Match win: player 1 wins 3 rounds -> after 3rd ROUND_OVER, press -> Game_State 4, winner_id 1. Press after hold -> MENU, scores 0.
- Priority: Reset_Round and Crash=2'b01 same cycle in ROUND_RUN -> ROUND_READY, no score change. Reset_n=0 mid-ROUND_OVER -> all reset values next cycle.

Source files
------------

// File: rtl/match_state_ctrl_pkg.sv
// Shared types, key codes and helper functions for the Tron match controller.
package tron_game_pkg;

  typedef enum logic [2:0] {
    MENU        = 3'd0,
    ROUND_READY = 3'd1,
    ROUND_RUN   = 3'd2,
    ROUND_OVER  = 3'd3,
    MATCH_OVER  = 3'd4
  } game_state_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_DOWN  = 8'h51;

  // Helpers work on a 4-bit mask (the largest supported player count);
  // callers zero-extend narrower masks.
  function automatic logic [2:0] popcount(input logic [3:0] v);
    logic [2:0] c;
    c = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  function automatic logic [1:0] lowest_index(input logic [3:0] v);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && v[i]) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/match_state_ctrl_key_edge_detect.sv
// Registers the keycode and flags a press on any change to a non-zero code.
module key_edge_detect (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  output logic       press,
  output logic [7:0] old_keycode
);

  // Previous-cycle keycode, captured every cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) old_keycode <= '0;
    else          old_keycode <= keycode;
  end

  assign press = (keycode != 8'h00) && (keycode != old_keycode);

endmodule

// File: rtl/match_state_ctrl.sv
// N-player Tron match controller: menu/map select, rounds, scoring, match win.
module match_state_ctrl
  import tron_game_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_MAPS      = 2,
  parameter int ROUNDS_TO_WIN = 3,
  parameter int HOLD_CYCLES   = 16,
  localparam int PID_W   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int BG_W    = $clog2(NUM_MAPS + 1),
  localparam int SCORE_W = $clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           Reset_Game,
  input  logic                           Reset_Round,
  input  logic [7:0]                     keycode,
  input  logic [NUM_PLAYERS-1:0]         Crash,
  output logic [2:0]                     Game_State,
  output logic [BG_W-1:0]                background_select,
  output logic                           load_background,
  output logic [NUM_PLAYERS-1:0]         alive,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [PID_W-1:0]               winner_id,
  output logic                           winner_valid
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  game_state_t                    state_q, state_d;
  logic [BG_W-1:0]                map_q, map_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
  logic [NUM_PLAYERS-1:0]         alive_q, alive_d, alive_n;
  logic [PID_W-1:0]               wid_q, wid_d, match_idx;
  logic                           wv_q, wv_d;
  logic [HOLD_W-1:0]              hold_q, hold_d;
  logic                           load_q, load_d;
  logic                           press, match_won;
  logic [3:0]                     surv;
  logic [2:0]                     surv_cnt;
  logic [1:0]                     surv_idx;
  logic [SCORE_W-1:0]             cur_score;
  logic [7:0]                     unused_key_prev;

  key_edge_detect u_key (
    .clk         (Clk),
    .reset_n     (Reset_n),
    .keycode     (keycode),
    .press       (press),
    .old_keycode (unused_key_prev)
  );

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= MENU;
      map_q    <= '0;
      scores_q <= '0;
      alive_q  <= '1;
      wid_q    <= '0;
      wv_q     <= 1'b0;
      hold_q   <= '0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      map_q    <= map_d;
      scores_q <= scores_d;
      alive_q  <= alive_d;
      wid_q    <= wid_d;
      wv_q     <= wv_d;
      hold_q   <= hold_d;
      load_q   <= load_d;
    end
  end

  // Next-state and next-datapath logic, Reset_Game > Reset_Round > Crash > press.
  always_comb begin
    state_d  = state_q;
    map_d    = map_q;
    scores_d = scores_q;
    alive_d  = alive_q;
    wid_d    = wid_q;
    wv_d     = wv_q;
    hold_d   = hold_q;
    cur_score = '0;

    alive_n  = alive_q & ~Crash;
    surv     = '0;
    surv[NUM_PLAYERS-1:0] = alive_n;
    surv_cnt = popcount(surv);
    surv_idx = lowest_index(surv);

    match_won = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (!match_won && scores_q[i*SCORE_W +: SCORE_W] == SCORE_W'(ROUNDS_TO_WIN)) begin
        match_won = 1'b1;
        match_idx = PID_W'(i);
      end
    end

    if (Reset_Game) begin
      state_d  = MENU;
      scores_d = '0;
      alive_d  = '1;
    end else begin
      case (state_q)
        MENU: begin
          if (press) begin
            if (keycode == KEY_W || keycode == KEY_UP) begin
              map_d = (map_q == BG_W'(NUM_MAPS - 1)) ? '0 : map_q + BG_W'(1);
            end else if (keycode == KEY_S || keycode == KEY_DOWN) begin
              map_d = (map_q == '0) ? BG_W'(NUM_MAPS - 1) : map_q - BG_W'(1);
            end else if (keycode == KEY_ENTER) begin
              state_d = ROUND_READY;
              alive_d = '1;
            end
          end
        end
        ROUND_READY: begin
          alive_d = '1;
          if (press) state_d = ROUND_RUN;
        end
        ROUND_RUN: begin
          if (Reset_Round) begin
            state_d = ROUND_READY;
            alive_d = '1;
          end else begin
            alive_d = alive_n;
            if (surv_cnt <= 3'd1) begin
              state_d = ROUND_OVER;
              hold_d  = HOLD_W'(HOLD_CYCLES - 1);
              if (surv_cnt == 3'd1) begin
                cur_score = scores_q[int'(surv_idx)*SCORE_W +: SCORE_W];
                if (cur_score != SCORE_W'(ROUNDS_TO_WIN)) begin
                  scores_d[int'(surv_idx)*SCORE_W +: SCORE_W] = cur_score + SCORE_W'(1);
                end
                wid_d = PID_W'(surv_idx);
                wv_d  = 1'b1;
              end else begin
                wv_d = 1'b0;
              end
            end
          end
        end
        ROUND_OVER: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else if (press) begin
            if (match_won) begin
              state_d = MATCH_OVER;
              hold_d  = HOLD_W'(HOLD_CYCLES - 1);
            end else begin
              state_d = ROUND_READY;
              alive_d = '1;
            end
          end
        end
        MATCH_OVER: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else if (press) begin
            state_d  = MENU;
            scores_d = '0;
            alive_d  = '1;
          end
        end
        default: state_d = MENU;
      endcase
    end

    load_d = (state_d == ROUND_READY) && (state_q != ROUND_READY);
  end

  // Output decode from registered state.
  always_comb begin
    Game_State        = state_q;
    load_background   = load_q;
    alive             = alive_q;
    scores            = scores_q;
    background_select = (state_q == MENU || state_q == MATCH_OVER) ? '0 : map_q + BG_W'(1);
    winner_id         = (state_q == MATCH_OVER) ? match_idx : wid_q;
    winner_valid      = (state_q == MATCH_OVER) ? 1'b1 :
                        (state_q == ROUND_OVER) ? wv_q : 1'b0;
  end

endmodule
